// File: rtl/lfsr_param_gen.sv
// lfsr_param_gen: parametrised Fibonacci LFSR with a valid/ready output word
// register, runtime seed load, all-zero lockup flag and full-period wrap pulse.
// Optional build macro LFSR_LOCKUP_RECOVER_EN: a zero seed write is replaced by
// DEFAULT_SEED and Lockup_SO pulses for one cycle instead of latching high.
module lfsr_param_gen #(
  parameter int unsigned       DEGREE       = 8,
  parameter logic [DEGREE-1:0] TAPS         = 8'hF3,
  parameter int unsigned       OUT_WIDTH    = 1,
  parameter logic [DEGREE-1:0] DEFAULT_SEED = {{(DEGREE-1){1'b0}}, 1'b1}
) (
  input  logic                 Clk_CI,
  input  logic                 Rst_RBI,
  input  logic                 En_SI,
  input  logic                 SeedWr_DI,
  input  logic [DEGREE-1:0]    Seed_DI,
  input  logic                 Ready_SI,
  output logic                 Valid_SO,
  output logic [OUT_WIDTH-1:0] LFSR_DO,
  output logic [DEGREE-1:0]    State_DO,
  output logic                 Lockup_SO,
  output logic                 PeriodWrap_SO
);

  // Architectural state
  logic [DEGREE-1:0]    state_reg, state_next;
  logic [DEGREE-1:0]    ref_reg, ref_next;
  logic                 valid_reg, valid_next;
  logic [OUT_WIDTH-1:0] data_reg, data_next;
  logic                 lockup_reg, lockup_next;
  logic                 wrap_reg, wrap_next;
  logic                 seed_reject;

  // Combinational step chain: chain[0] is the current state, chain[k+1] the
  // state after k+1 steps. word[k] is the bit shifted out at step k.
  logic [OUT_WIDTH:0][DEGREE-1:0] chain;
  logic [OUT_WIDTH-1:0]           word;
  logic [OUT_WIDTH-1:0]           hit;
  logic                           wrap_hit;
  logic                           advance;

  assign chain[0] = state_reg;

  generate
    for (genvar gi = 0; gi < OUT_WIDTH; gi++) begin : g_step
      assign word[gi]     = chain[gi][DEGREE-1];
      assign chain[gi+1]  = {chain[gi][DEGREE-2:0], ^(chain[gi] & TAPS)};
      assign hit[gi]      = (chain[gi+1] == ref_reg);
    end
  endgenerate

  assign wrap_hit = |hit;

  // A new word may be produced when enabled, no seed write is pending and the
  // output register is empty or being drained this cycle.
  assign advance = En_SI & ~SeedWr_DI & (~valid_reg | Ready_SI);

  // Next-state selection: seed write beats advance beats plain drain
  always_comb begin
    state_next  = state_reg;
    ref_next    = ref_reg;
    valid_next  = valid_reg;
    data_next   = data_reg;
    wrap_next   = 1'b0;
    seed_reject = 1'b0;
    if (SeedWr_DI) begin
`ifdef LFSR_LOCKUP_RECOVER_EN
      if (Seed_DI == '0) begin
        state_next  = DEFAULT_SEED;
        ref_next    = DEFAULT_SEED;
        seed_reject = 1'b1;
      end else begin
        state_next  = Seed_DI;
        ref_next    = Seed_DI;
      end
`else
      state_next = Seed_DI;
      ref_next   = Seed_DI;
`endif
      // Pending word is flushed; the data register keeps its old contents.
      valid_next = 1'b0;
    end else if (advance) begin
      state_next = chain[OUT_WIDTH];
      data_next  = word;
      valid_next = 1'b1;
      wrap_next  = wrap_hit;
    end else if (valid_reg && Ready_SI) begin
      valid_next = 1'b0;
    end
    // Lockup tracks the registered state; a rejected zero seed flags once.
    lockup_next = (state_next == '0) | seed_reject;
  end

  // Register update with synchronous active-low reset
  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      state_reg  <= DEFAULT_SEED;
      ref_reg    <= DEFAULT_SEED;
      valid_reg  <= 1'b0;
      data_reg   <= '0;
      lockup_reg <= 1'b0;
      wrap_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      ref_reg    <= ref_next;
      valid_reg  <= valid_next;
      data_reg   <= data_next;
      lockup_reg <= lockup_next;
      wrap_reg   <= wrap_next;
    end
  end

  assign Valid_SO      = valid_reg;
  assign LFSR_DO       = data_reg;
  assign State_DO      = state_reg;
  assign Lockup_SO     = lockup_reg;
  assign PeriodWrap_SO = wrap_reg;

endmodule

// File: tb/tb_lfsr_param_gen.sv
// tb_lfsr_param_gen: directed checks of lfsr_param_gen with default
// parameters (1-bit words) and a second instance producing 8-bit words.
module tb_lfsr_param_gen;

  logic       clk;
  logic       rst_n;
  // 1-bit instance stimulus / observation
  logic       en, seed_wr, ready;
  logic [7:0] seed;
  logic       valid;
  logic [0:0] data;
  logic [7:0] state;
  logic       lockup, wrap;
  // 8-bit instance stimulus / observation
  logic       en8, seed_wr8, ready8;
  logic [7:0] seed8;
  logic       valid8;
  logic [7:0] data8;
  logic [7:0] state8;
  logic       lockup8, wrap8;

  int errors = 0;
  int checks = 0;

  // Reference sequence from seed 0x01 with taps 0xF3
  logic [7:0] exp_state [8] = '{8'h03, 8'h06, 8'h0D, 8'h1B, 8'h37, 8'h6E, 8'hDD, 8'hBA};
  logic       exp_bit   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  lfsr_param_gen dut (
    .Clk_CI(clk), .Rst_RBI(rst_n), .En_SI(en), .SeedWr_DI(seed_wr),
    .Seed_DI(seed), .Ready_SI(ready), .Valid_SO(valid), .LFSR_DO(data),
    .State_DO(state), .Lockup_SO(lockup), .PeriodWrap_SO(wrap)
  );

  lfsr_param_gen #(.OUT_WIDTH(8)) dut8 (
    .Clk_CI(clk), .Rst_RBI(rst_n), .En_SI(en8), .SeedWr_DI(seed_wr8),
    .Seed_DI(seed8), .Ready_SI(ready8), .Valid_SO(valid8), .LFSR_DO(data8),
    .State_DO(state8), .Lockup_SO(lockup8), .PeriodWrap_SO(wrap8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_seed(input logic [7:0] s);
    seed_wr = 1'b1;
    seed    = s;
    tick();
    seed_wr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (data !== 1'b0) begin errors++; $display("FAIL reset_data got=%b exp=0", data); end
    checks++; if (state !== 8'h01) begin errors++; $display("FAIL reset_state got=%h exp=01", state); end
    checks++; if (lockup !== 1'b0 || wrap !== 1'b0) begin errors++; $display("FAIL reset_flags got=%b%b exp=00", lockup, wrap); end
    checks++; if (state8 !== 8'h01 || valid8 !== 1'b0 || data8 !== 8'h00) begin errors++; $display("FAIL reset_w8 got=%h/%b/%h exp=01/0/00", state8, valid8, data8); end
    rst_n = 1'b1;
    $display("reset: state=%h valid=%b data=%b", state, valid, data);
  endtask

  task automatic test_sequence();
    en = 1'b1; ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d] got=%b exp=1", k, valid); end
      checks++; if (data !== exp_bit[k]) begin errors++; $display("FAIL seq_bit[%0d] got=%b exp=%b", k, data, exp_bit[k]); end
      checks++; if (state !== exp_state[k]) begin errors++; $display("FAIL seq_state[%0d] got=%h exp=%h", k, state, exp_state[k]); end
      $display("seq step %0d: bit=%b state=%h", k, data, state);
    end
    en = 1'b0;
    tick();
    checks++; if (valid !== 1'b0 || state !== 8'hBA) begin errors++; $display("FAIL seq_drain got=%b/%h exp=0/ba", valid, state); end
    $display("seq drain: valid=%b state=%h", valid, state);
  endtask

  task automatic test_width8();
    en8 = 1'b1; ready8 = 1'b1;
    tick();
    en8 = 1'b0;
    checks++; if (data8 !== 8'h80) begin errors++; $display("FAIL w8_data got=%h exp=80", data8); end
    checks++; if (state8 !== 8'hBA || valid8 !== 1'b1) begin errors++; $display("FAIL w8_state got=%h/%b exp=ba/1", state8, valid8); end
    $display("width8 word: data=%h state=%h", data8, state8);
  endtask

  task automatic test_period();
    logic seen [256];
    int   bad_dup, bad_wrap;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    bad_dup = 0; bad_wrap = 0;
    load_seed(8'h01);
    checks++; if (state !== 8'h01 || valid !== 1'b0 || wrap !== 1'b0) begin errors++; $display("FAIL period_seed got=%h/%b/%b exp=01/0/0", state, valid, wrap); end
    en = 1'b1; ready = 1'b1;
    for (int k = 1; k <= 255; k++) begin
      tick();
      if (k < 255) begin
        checks++;
        if (state == 8'h00 || seen[state] || wrap !== 1'b0) begin
          errors++;
          $display("FAIL period_step[%0d] got state=%h wrap=%b exp distinct nonzero, wrap=0", k, state, wrap);
        end
        seen[state] = 1'b1;
      end
    end
    en = 1'b0;
    checks++; if (wrap !== 1'b1 || state !== 8'h01) begin errors++; $display("FAIL period_wrap got=%b/%h exp=1/01", wrap, state); end
    $display("period step 255: wrap=%b state=%h", wrap, state);
    tick();
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL period_pulse got=%b exp=0", wrap); end
  endtask

  task automatic test_back_to_back();
    load_seed(8'h01);
    en = 1'b1; ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++; if (data !== exp_bit[k] || state !== exp_state[k]) begin errors++; $display("FAIL bp_pre[%0d] got=%b/%h exp=%b/%h", k, data, state, exp_bit[k], exp_state[k]); end
    end
    ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if (valid !== 1'b1 || data !== 1'b1 || state !== 8'hBA) begin errors++; $display("FAIL bp_hold[%0d] got=%b/%b/%h exp=1/1/ba", c, valid, data, state); end
      $display("backpressure cycle %0d: valid=%b bit=%b state=%h", c, valid, data, state);
    end
    ready = 1'b1;
    tick();
    checks++; if (valid !== 1'b1 || data !== 1'b1 || state !== 8'h74) begin errors++; $display("FAIL bp_resume got=%b/%b/%h exp=1/1/74", valid, data, state); end
    $display("backpressure resume: bit=%b state=%h", data, state);
  endtask

  task automatic test_seed_write();
    // en=1, ready=1 and a word pending: the seed write must flush it
    load_seed(8'hA5);
    checks++; if (valid !== 1'b0 || state !== 8'hA5) begin errors++; $display("FAIL seed_load got=%b/%h exp=0/a5", valid, state); end
    checks++; if (wrap !== 1'b0 || data !== 1'b1) begin errors++; $display("FAIL seed_flags got wrap=%b data=%b exp=0/1", wrap, data); end
    $display("seed write: state=%h valid=%b", state, valid);
    tick();
    checks++; if (valid !== 1'b1 || data !== 1'b1 || state !== 8'h4B) begin errors++; $display("FAIL seed_adv got=%b/%b/%h exp=1/1/4b", valid, data, state); end
    $display("seed advance: bit=%b state=%h", data, state);
    en = 1'b0;
    tick();
  endtask

  task automatic test_lockup();
    en = 1'b0; ready = 1'b1;
    load_seed(8'h00);
`ifdef LFSR_LOCKUP_RECOVER_EN
    checks++; if (state !== 8'h01 || lockup !== 1'b1) begin errors++; $display("FAIL lock_reject got=%h/%b exp=01/1", state, lockup); end
    tick();
    checks++; if (state !== 8'h01 || lockup !== 1'b0) begin errors++; $display("FAIL lock_pulse got=%h/%b exp=01/0", state, lockup); end
    $display("lockup recover: state=%h lockup=%b", state, lockup);
`else
    checks++; if (state !== 8'h00 || lockup !== 1'b1) begin errors++; $display("FAIL lock_load got=%h/%b exp=00/1", state, lockup); end
    en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (valid !== 1'b1 || data !== 1'b0 || state !== 8'h00 || lockup !== 1'b1) begin errors++; $display("FAIL lock_word[%0d] got=%b/%b/%h/%b exp=1/0/00/1", k, valid, data, state, lockup); end
      $display("lockup word %0d: bit=%b state=%h lockup=%b", k, data, state, lockup);
    end
    en = 1'b0;
    load_seed(8'h01);
    checks++; if (lockup !== 1'b0 || state !== 8'h01) begin errors++; $display("FAIL lock_clear got=%b/%h exp=0/01", lockup, state); end
`endif
  endtask

  task automatic test_reset_midstream();
    load_seed(8'hA5);
    en = 1'b1; ready = 1'b0;
    tick();
    // reset pulse confined between edges must be ignored
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    checks++; if (valid !== 1'b1 || data !== 1'b1 || state !== 8'h4B) begin errors++; $display("FAIL rst_glitch got=%b/%b/%h exp=1/1/4b", valid, data, state); end
    $display("reset glitch: valid=%b bit=%b state=%h", valid, data, state);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    en = 1'b0;
    checks++; if (valid !== 1'b0 || data !== 1'b0 || state !== 8'h01 || lockup !== 1'b0) begin errors++; $display("FAIL rst_mid got=%b/%b/%h/%b exp=0/0/01/0", valid, data, state, lockup); end
    $display("reset midstream: valid=%b bit=%b state=%h", valid, data, state);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; seed_wr = 1'b0; seed = 8'h00; ready = 1'b0;
    en8 = 1'b0; seed_wr8 = 1'b0; seed8 = 8'h00; ready8 = 1'b0;
    #1;
    test_reset();
    test_sequence();
    test_width8();
    test_period();
    test_back_to_back();
    test_seed_write();
    test_lockup();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
